// File: rtl/mesh_pkg.sv
// rtl/mesh_pkg.sv - shared types and constants for the shearsort mesh controller
package mesh_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SORT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Row phases bracket every column phase, so a sqrt(n) mesh needs 2*log+1 phases.
  function automatic int num_phases(input int log_sqrt_n);
    return 2 * log_sqrt_n + 1;
  endfunction

endpackage

// File: rtl/shearsort_step_cnt.sv
// rtl/shearsort_step_cnt.sv - step-within-phase and phase counters for the shearsort sequencer
module shearsort_step_cnt
  import mesh_pkg::*;
#(
  parameter int SQRT_N     = 4,
  parameter int LOG_SQRT_N = 2,
  parameter int PW         = $clog2(2 * LOG_SQRT_N + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  adv,
  output logic [LOG_SQRT_N-1:0] step_cnt,
  output logic [PW-1:0]         phase_idx,
  output logic                  last
);

  localparam int LAST_PHASE = num_phases(LOG_SQRT_N) - 1;
  localparam logic [LOG_SQRT_N-1:0] LAST_STEP = LOG_SQRT_N'(SQRT_N - 1);

  logic step_wrap;

  assign step_wrap = (step_cnt == LAST_STEP);
  assign last      = step_wrap && (phase_idx == PW'(LAST_PHASE));

  // Clearing on the final step leaves both counters at zero for DONE/IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt  <= '0;
      phase_idx <= '0;
    end else if (clr || (adv && last)) begin
      step_cnt  <= '0;
      phase_idx <= '0;
    end else if (adv) begin
      step_cnt <= step_cnt + 1'b1;
      if (step_wrap) begin
        phase_idx <= phase_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/shearsort_ctrl.sv
// rtl/shearsort_ctrl.sv - load/sort/done sequencer driving the PE mesh of a shearsort
module shearsort_ctrl
  import mesh_pkg::*;
#(
  parameter int SQRT_N     = 4,
  parameter int LOG_SQRT_N = 2,
  parameter int PW         = $clog2(2 * LOG_SQRT_N + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stall,
  output logic                  load,
  output logic                  step_en,
  output logic                  phase_col,
  output logic                  step_odd,
  output logic [PW-1:0]         phase_idx,
  output logic [LOG_SQRT_N-1:0] step_cnt,
  output logic                  busy,
  output logic                  done
);

  state_t state;
  logic   adv;
  logic   last;
  logic   cnt_clr;

  // Counters only move on a cycle in which a compare-exchange actually ran.
  assign adv     = (state == SORT) && step_en;
  assign cnt_clr = (state != SORT);

  shearsort_step_cnt #(
    .SQRT_N     (SQRT_N),
    .LOG_SQRT_N (LOG_SQRT_N),
    .PW         (PW)
  ) u_step_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (cnt_clr),
    .adv       (adv),
    .step_cnt  (step_cnt),
    .phase_idx (phase_idx),
    .last      (last)
  );

  assign phase_col = phase_idx[0];
  assign step_odd  = step_cnt[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      load    <= 1'b0;
      step_en <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      load <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            load  <= 1'b1;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          state   <= SORT;
          step_en <= 1'b1;
        end
        SORT: begin
          // A stall sampled here freezes the following cycle; the last step always completes.
          if (step_en && last) begin
            state   <= DONE;
            step_en <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            step_en <= !stall;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          step_en <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shearsort_ctrl.sv
// tb/tb_shearsort_ctrl.sv - randomized self-checking bench for shearsort_ctrl against a step-index model
module tb_shearsort_ctrl;

  localparam int N  = 4;
  localparam int L  = 2;
  localparam int T  = N * (2 * L + 1);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic       load, step_en, phase_col, step_odd, busy, done;
  logic [2:0] phase_idx;
  logic [1:0] step_cnt;

  logic       start8 = 1'b0;
  logic       stall8 = 1'b0;
  logic       load8, step_en8, phase_col8, step_odd8, busy8, done8;
  logic [2:0] phase_idx8;
  logic [2:0] step_cnt8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shearsort_ctrl #(.SQRT_N(4), .LOG_SQRT_N(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .load(load), .step_en(step_en), .phase_col(phase_col), .step_odd(step_odd),
    .phase_idx(phase_idx), .step_cnt(step_cnt), .busy(busy), .done(done)
  );

  shearsort_ctrl #(.SQRT_N(8), .LOG_SQRT_N(3)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .stall(stall8),
    .load(load8), .step_en(step_en8), .phase_col(phase_col8), .step_odd(step_odd8),
    .phase_idx(phase_idx8), .step_cnt(step_cnt8), .busy(busy8), .done(done8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cur();
    return {21'd0, load, step_en, phase_col, step_odd, phase_idx, step_cnt, busy, done};
  endfunction

  function automatic logic [31:0] cur8();
    return {20'd0, load8, step_en8, phase_col8, step_odd8, phase_idx8, step_cnt8, busy8, done8};
  endfunction

  // Expected output tuple from plain arithmetic on phase/step numbers.
  function automatic logic [31:0] mk(input bit l, input bit se, input int ph, input int st,
                                     input bit b, input bit d);
    return {21'd0, l, se, 1'(ph % 2), 1'(st % 2), 3'(ph), 2'(st), b, d};
  endfunction

  // mode: 0 clean, 1 random stall, 2 three-cycle stall at phase 2 step 1,
  //       3 start held high, 4 async reset in phase 3
  task automatic run_sort(input int mode, output int done_cyc);
    int k, cyc, left;
    bit frozen, s, fired;
    done_cyc = -1;
    @(posedge clk); #1;
    start = 1'b1;
    if (mode == 1) stall = 1'b1;
    @(posedge clk); #1;
    if (mode != 3) start = 1'b0;
    if (mode == 1) stall = 1'b1;
    cyc = 1;
    @(negedge clk);
    chk("load_cycle", cur(), mk(1, 0, 0, 0, 1, 0));
    @(posedge clk); #1;
    cyc = 2; k = 0; frozen = 0; left = 0; fired = 0;
    while (k < T && cyc < 400) begin
      s = 0;
      if (mode == 1) s = ($urandom_range(0, 3) == 0);
      if (mode == 2 && k == 9 && !frozen && !fired) begin
        left = 3;
        fired = 1;
      end
      if (left > 0) begin
        s = 1;
        left--;
      end
      stall = s;
      @(negedge clk);
      chk(frozen ? "frozen_cycle" : "step_cycle", cur(), mk(0, !frozen, k / N, k % N, 1, 0));
      if (mode == 4 && k == 13 && !frozen) begin
        #1 rst = 1'b1;
        stall = 1'b0;
        #1 chk("async_reset_outputs", cur(), 32'd0);
        return;
      end
      @(posedge clk); #1;
      cyc++;
      if (!frozen) k++;
      frozen = s;
    end
    stall = 1'b0;
    if (cyc >= 400) chk("sort_timeout", 32'd1, 32'd0);
    @(negedge clk);
    chk("done_cycle", cur(), mk(0, 0, 0, 0, 0, 1));
    done_cyc = cyc;
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_after_done", cur(), 32'd0);
    if (mode == 3) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("reload_after_idle", cur(), mk(1, 0, 0, 0, 1, 0));
      start = 1'b0;
    end
  endtask

  initial begin
    int dc, n, dc8;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", cur(), 32'd0);
    chk("reset_outputs8", cur8(), 32'd0);
    start = 1'b1;
    @(posedge clk); #1;
    chk("start_ignored_in_reset", cur(), 32'd0);
    start = 1'b0;
    rst = 1'b0;

    run_sort(0, dc);
    chk("done_cycle_plain", dc, 22);

    run_sort(2, dc);
    chk("done_cycle_stalled", dc, 25);

    for (int r = 0; r < 3; r++) run_sort(1, dc);

    run_sort(3, dc);
    chk("done_cycle_start_held", dc, 22);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;

    run_sort(4, dc);
    @(posedge clk);
    @(negedge clk);
    chk("held_reset_outputs", cur(), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_done_after_abort", cur(), 32'd0);
    end
    run_sort(0, dc);
    chk("done_cycle_after_abort", dc, 22);

    @(posedge clk); #1 start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    n = 0;
    dc8 = -1;
    for (int c = 1; c < 200; c++) begin
      @(negedge clk);
      if (c == 1) chk("load8", cur8(), {20'd0, 1'b1, 9'd0, 1'b1, 1'b0});
      if (step_en8) begin
        chk("step8", {phase_idx8, phase_col8, step_odd8, step_cnt8},
            {3'(n / 8), 1'((n / 8) % 2), 1'(n % 2), 3'(n % 8)});
        n++;
      end
      if (done8) begin
        dc8 = c;
        break;
      end
      @(posedge clk);
    end
    chk("steps8_total", n, 56);
    chk("done_cycle8", dc8, 58);
    @(posedge clk);
    @(negedge clk);
    chk("idle8", cur8(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
